// File: rtl/pad_msg_encoder_if.sv
// Purpose: byte-stream handshake between the pad encoder and its consumer.
// Latency: none, wires only.
// Backpressure: the consumer holds msg_ready low to stall the stream.
interface pad_msg_encoder_if;
    logic [7:0] music_msg;
    logic       msg_valid;
    logic       msg_ready;

    modport master (
        output music_msg,
        output msg_valid,
        input  msg_ready
    );

    modport slave (
        input  music_msg,
        input  msg_valid,
        output msg_ready
    );
endinterface

// File: rtl/pad_msg_encoder.sv
// Purpose: sync + debounce 8 pads, encode press/release edges as music_msg bytes.
// Latency: DEBOUNCE_CYCLES+2 .. DEBOUNCE_CYCLES+9 cycles from a raw change to msg_valid.
// Backpressure: a full FIFO holds the scanner; a repeated edge on a still-pending bit is dropped and flags overflow.
module pad_msg_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic [7:0]         button,
    output logic               overflow,
    pad_msg_encoder_if.master  msg
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // synchroniser and debounce state
    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] stable;
    logic [7:0] stable_nxt;
    logic [7:0] deb_cnt     [8];
    logic [7:0] deb_cnt_nxt [8];
    logic [7:0] rise;
    logic [7:0] fall;

    // pending edge events
    logic [7:0] pend_on;
    logic [7:0] pend_off;
    logic [7:0] clr_on;
    logic [7:0] clr_off;
    logic [7:0] drop;

    // scanner
    logic [2:0] scan;
    logic       scan_adv;
    logic       push;
    logic [7:0] push_dat;

    // message FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;

    assign full          = (count == CNT_FULL);
    assign msg.msg_valid = (count != '0);
    assign msg.music_msg = mem[rd_ptr];
    assign pop           = msg.msg_valid & msg.msg_ready;

    // per-bit debounce: accept sync2 once it differed from stable for DEBOUNCE_CYCLES samples
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < 8; i++) begin
            deb_cnt_nxt[i] = 8'd0;
            if (sync2[i] != stable[i]) begin
                if (deb_cnt[i] == DEB_LAST) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    deb_cnt_nxt[i] = deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign rise = stable_nxt & ~stable;
    assign fall = stable & ~stable_nxt;

    // scanner: serve the pad under the pointer, on-message before off-message, hold while it has work
    always_comb begin
        scan_adv = 1'b0;
        push     = 1'b0;
        push_dat = 8'h00;
        clr_on   = 8'h00;
        clr_off  = 8'h00;
        if (!pend_on[scan] && !pend_off[scan]) begin
            scan_adv = 1'b1;
        end else if (!full || pop) begin
            push = 1'b1;
            if (pend_on[scan]) begin
                clr_on[scan] = 1'b1;
                push_dat     = {3'b111, 2'b00, scan};
            end else begin
                clr_off[scan] = 1'b1;
                push_dat      = {3'b110, 2'b00, scan};
            end
        end
    end

    // an edge is lost when its pending bit is still set and not being drained this cycle
    assign drop = (rise & pend_on & ~clr_on) | (fall & pend_off & ~clr_off);

    // synchroniser, debounce and pending-event registers
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync1    <= 8'h00;
            sync2    <= 8'h00;
            stable   <= 8'h00;
            pend_on  <= 8'h00;
            pend_off <= 8'h00;
            overflow <= 1'b0;
            scan     <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                deb_cnt[i] <= 8'd0;
            end
        end else begin
            sync1    <= button;
            sync2    <= sync1;
            stable   <= stable_nxt;
            pend_on  <= (pend_on & ~clr_on) | rise;
            pend_off <= (pend_off & ~clr_off) | fall;
            overflow <= overflow | (|drop);
            if (scan_adv) begin
                scan <= scan + 3'd1;
            end
            for (int i = 0; i < 8; i++) begin
                deb_cnt[i] <= deb_cnt_nxt[i];
            end
        end
    end

    // message FIFO: push from the scanner, pop on the handshake, both allowed in one cycle
    always_ff @(posedge clkin) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/pad_msg_encoder.md
# pad_msg_encoder

Launchpad button front end: synchronises and debounces the 8 pad buttons, detects press and release edges, and encodes each edge as an 8-bit `music_msg` byte. Bytes are queued in a small FIFO and offered on a valid/ready handshake. It produces the byte stream that `top` consumes on its `music_msg` input, so pads drive the same message path the bench currently stimulates by hand.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples needed to accept a level change (legal range 2..255).
- `FIFO_DEPTH`, default 4: message FIFO entries (power of two).

Ports:
- `clkin` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `button` in 8: raw asynchronous pad levels; 1 = pressed.
- `music_msg` out 8: FIFO head byte; meaningful only while `msg_valid` = 1.
- `msg_valid` out 1: FIFO non-empty.
- `msg_ready` in 1: consumer accepts the head on a cycle where `msg_valid` & `msg_ready`.
- `overflow` out 1: sticky; set when an edge event is dropped; cleared only by `rst`.

## Operation
- **Message format**
  - `[7:5]` = 3'b111 for a press (note on), 3'b110 for a release (note off).
  - `[4:3]` = 2'b00.
  - `[2:0]` = pad index.
  - Example: press of `button[1]` = 8'hE1; release of `button[1]` = 8'hC1.
- **Synchroniser:** 2-flop per bit (`sync1`, `sync2`).
- **Debounce, per bit:**
  - Counter increments each cycle `sync2` != `stable`.
  - Counter clears to 0 when `sync2` == `stable`.
  - When the counter would reach `DEBOUNCE_CYCLES`, `stable` takes `sync2` and the counter clears.
- **Edge capture:**
  - On a `stable` 0->1 update, set `pend_on[i]`.
  - On a `stable` 1->0 update, set `pend_off[i]`.
  - If the bit to be set is already 1, the event is dropped and `overflow` is set.
- **Scanner:**
  - 3-bit pointer `scan` cycles 0..7, wrapping 7->0.
  - At pointer i, with any pending bit and FIFO not full: push one message and clear that pending bit.
  - If both `pend_on[i]` and `pend_off[i]` are set, the on message is pushed first. The pointer holds at i until `pend_off[i]` is also pushed.
  - The pointer advances when i has nothing pending.
  - The pointer holds while i has a pending bit and the FIFO is full.
- **FIFO:**
  - Push from the scanner; pop on `msg_valid` & `msg_ready`.
  - Simultaneous push and pop when full: both occur, count unchanged.
  - Simultaneous push and pop when empty: push only; the pop is not possible since `msg_valid` = 0.
  - `music_msg` = `mem[rd_ptr]`; pointers wrap modulo `FIFO_DEPTH`.
- **Reset state:** `sync1`, `sync2`, `stable`, counters, pending bits, `scan`, FIFO pointers/count, and `overflow` all 0. Buttons held during reset produce a press message after reset, following normal debounce.

## Timing
- Reset values of outputs: `music_msg` = 8'h00, `msg_valid` = 0, `overflow` = 0.
- Raw change sampled at edge N:
  - `sync2` updated at N+1.
  - `stable` and pending updated at edge N+1+`DEBOUNCE_CYCLES`.
  - Earliest push at N+2+`DEBOUNCE_CYCLES`, with `msg_valid` high after that edge.
  - Latest push, FIFO not full and no other pending, at N+9+`DEBOUNCE_CYCLES`.
- Glitches shorter than `DEBOUNCE_CYCLES` samples produce no message.
- Handshake:
  - `music_msg` is stable while `msg_valid` = 1 and not popped.
  - After a pop, the next byte (or `msg_valid` = 0) appears the following cycle.
  - Throughput is 1 byte/cycle.
- Message order:
  - Per pad: messages are emitted in edge order.
  - Across pads with concurrent pending events: scan order from the current pointer.
- `rst` asserted mid-operation flushes the FIFO and all pending events on that edge. No partial message survives.

## Test plan
- **Single press/release:** `DEBOUNCE_CYCLES` = 4, `msg_ready` = 1. Set `button` = 8'h02 at edge N.
  - Required: 8'hE1 with `msg_valid` after edge N+6 .. N+13.
  - Then clear `button` to 8'h00. Required: 8'hC1.
- **Simultaneous press:** `button` 8'h00 -> 8'h81 with `scan` = 0 at the stable update.
  - Required: 8'hE0 then 8'hE7; no other bytes.
- **Glitch rejection:** `button[3]` high for 2 cycles, then low.
  - Required: no message; `msg_valid` stays 0; `overflow` = 0.
- **Backpressure:** `msg_ready` = 0; press and release pads 0..2 in sequence (6 events).
  - Required: 4 bytes queued, remainder held pending, `overflow` = 0.
  - Then `msg_ready` = 1. Required bytes in order: E0, C0, E1, C1, E2, C2.
- **Overflow:** `msg_ready` = 0 with the FIFO full and `pend_on[5]` set; release then press pad 5 again.
  - Required: `overflow` = 1 after the second stable press.
  - After drain: exactly one E5 and one C5 in that order.
- **Reset mid-operation:** with 3 bytes queued, assert `rst` for 1 cycle.
  - Required next cycle: `msg_valid` = 0, `music_msg` = 8'h00, `overflow` = 0.
  - A pad held through reset yields one press byte.
